// File: rtl/subdivide_pkg.sv
// Shared types and constants for the subdivided-page leaf arbiter.
// Packet layout: bit VALID_BIT marks a live packet.
package subdivide_pkg;

    localparam int PACKET_W     = 49;
    localparam int VALID_BIT    = PACKET_W - 1;
    localparam int ADDR_SEL_DEF = 43;

    typedef logic [PACKET_W-1:0] packet_t;

    typedef enum logic {
        RR_P0 = 1'b0,
        RR_P1 = 1'b1
    } rr_t;

    function automatic logic pkt_valid(input packet_t p);
        return p[VALID_BIT];
    endfunction

endpackage

// File: rtl/subdivide_rr_arb2.sv
// Two-requester round-robin grant with a registered priority pointer.
// Grant is combinational; the pointer moves only on a taken grant.
module subdivide_rr_arb2
    import subdivide_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    rr_t rr;
    rr_t rr_next;

    // Priority pointer register, reset to requester 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr <= RR_P0;
        end else begin
            rr <= rr_next;
        end
    end

    // One-hot grant and pointer update after a taken grant.
    always_comb begin
        grant   = 2'b00;
        rr_next = rr;
        unique case (1'b1)
            (req == 2'b11): grant = (rr == RR_P0) ? 2'b01 : 2'b10;
            (req == 2'b01): grant = 2'b01;
            (req == 2'b10): grant = 2'b10;
            default:        grant = 2'b00;
        endcase
        if (advance && (|req)) begin
            rr_next = grant[0] ? RR_P1 : RR_P0;
        end
    end

endmodule

// File: rtl/subdivide_leaf_arbiter.sv
// Merges two sub-page packet streams onto one BFT leaf and steers
// leaf traffic back by address bit. Option: SUBDIV_ARB_PERF_EN.
module subdivide_leaf_arbiter #(
    parameter int PACKET_W     = subdivide_pkg::PACKET_W,
    parameter int ADDR_SEL_BIT = subdivide_pkg::ADDR_SEL_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PACKET_W-1:0] din_leaf_bft2interface,
    output logic [PACKET_W-1:0] dout_leaf_interface2bft,
    input  logic                resend,
    input  logic [PACKET_W-1:0] sp_dout_0,
    input  logic [PACKET_W-1:0] sp_dout_1,
    output logic [PACKET_W-1:0] sp_din_0,
    output logic [PACKET_W-1:0] sp_din_1,
    output logic                sp_resend_0,
    output logic                sp_resend_1
`ifdef SUBDIV_ARB_PERF_EN
    ,
    output logic [31:0]         grant_cnt_0,
    output logic [31:0]         grant_cnt_1,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int VB = PACKET_W - 1;

    logic [PACKET_W-1:0] sp_in    [2];
    logic [PACKET_W-1:0] slot_pkt [2];
    logic [1:0]          slot_full;
    logic [1:0]          sp_valid;
    logic [1:0]          grant;
    logic [1:0]          drain;
    logic                or_free;
    logic [PACKET_W-1:0] or_next;
    logic                dn_valid;
    logic                dn_sel;

    assign sp_in[0]    = sp_dout_0;
    assign sp_in[1]    = sp_dout_1;
    assign sp_valid    = {sp_dout_1[VB], sp_dout_0[VB]};
    assign or_free     = !dout_leaf_interface2bft[VB] || !resend;
    assign drain       = or_free ? grant : 2'b00;
    assign sp_resend_0 = slot_full[0];
    assign sp_resend_1 = slot_full[1];
    assign dn_valid    = din_leaf_bft2interface[VB];
    assign dn_sel      = din_leaf_bft2interface[ADDR_SEL_BIT];

    subdivide_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (slot_full),
        .advance (or_free),
        .grant   (grant)
    );

    // Winner's packet, or an empty packet when no slot is full.
    always_comb begin
        or_next = '0;
        unique case (1'b1)
            grant[0]: or_next = slot_pkt[0];
            grant[1]: or_next = slot_pkt[1];
            default:  or_next = '0;
        endcase
    end

    // Slot flags: load when empty and offered, clear when drained.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_full <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!slot_full[i] && sp_valid[i]) begin
                    slot_full[i] <= 1'b1;
                end else if (drain[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payloads are only meaningful while flagged full.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!slot_full[i] && sp_valid[i]) begin
                slot_pkt[i] <= sp_in[i];
            end
        end
    end

    // Output register holds under leaf resend, else takes the winner.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout_leaf_interface2bft <= '0;
        end else if (or_free) begin
            dout_leaf_interface2bft <= or_next;
        end
    end

    // Downstream steering, one register stage, no backpressure.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sp_din_0 <= '0;
            sp_din_1 <= '0;
        end else begin
            sp_din_0 <= (dn_valid && !dn_sel) ? din_leaf_bft2interface : '0;
            sp_din_1 <= (dn_valid && dn_sel) ? din_leaf_bft2interface : '0;
        end
    end

`ifdef SUBDIV_ARB_PERF_EN
    // Free-running wrap-around grant and stall counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_cnt_0 <= '0;
            grant_cnt_1 <= '0;
            stall_cnt   <= '0;
        end else begin
            grant_cnt_0 <= grant_cnt_0 + {31'd0, drain[0]};
            grant_cnt_1 <= grant_cnt_1 + {31'd0, drain[1]};
            stall_cnt   <= stall_cnt + {31'd0, !or_free};
        end
    end
`endif

endmodule

// File: tb/tb_subdivide_leaf_arbiter.sv
// Randomised and directed bench for subdivide_leaf_arbiter.
// Behavioural model plus per-source scoreboard; SUBDIV_ARB_PERF_EN aware.
module tb_subdivide_leaf_arbiter;

    localparam int W  = 49;
    localparam int VB = 48;
    localparam int AB = 43;
    localparam int SB = 40;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] din_leaf_bft2interface;
    logic [W-1:0] dout_leaf_interface2bft;
    logic         resend;
    logic [W-1:0] sp_dout_0;
    logic [W-1:0] sp_dout_1;
    logic [W-1:0] sp_din_0;
    logic [W-1:0] sp_din_1;
    logic         sp_resend_0;
    logic         sp_resend_1;
`ifdef SUBDIV_ARB_PERF_EN
    logic [31:0]  grant_cnt_0;
    logic [31:0]  grant_cnt_1;
    logic [31:0]  stall_cnt;
`endif

    subdivide_leaf_arbiter #(.PACKET_W(W), .ADDR_SEL_BIT(AB)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_bft2interface  (din_leaf_bft2interface),
        .dout_leaf_interface2bft (dout_leaf_interface2bft),
        .resend                  (resend),
        .sp_dout_0               (sp_dout_0),
        .sp_dout_1               (sp_dout_1),
        .sp_din_0                (sp_din_0),
        .sp_din_1                (sp_din_1),
        .sp_resend_0             (sp_resend_0),
        .sp_resend_1             (sp_resend_1)
`ifdef SUBDIV_ARB_PERF_EN
        ,
        .grant_cnt_0             (grant_cnt_0),
        .grant_cnt_1             (grant_cnt_1),
        .stall_cnt               (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: a one-deep mailbox per sub-page, a leaf output
    // that is refilled unless the leaf refuses it, alternating turns.
    bit           m_has  [2];
    logic [W-1:0] m_held [2];
    logic [W-1:0] m_out;
    logic [W-1:0] m_sp0;
    logic [W-1:0] m_sp1;
    int           m_turn;
    bit           m_loaded;
    int unsigned  m_g [2];
    int unsigned  m_stall;
    logic [W-1:0] sb0 [$];
    logic [W-1:0] sb1 [$];

    always @(posedge clk) begin : model
        logic [W-1:0] in_p [2];
        bit had [2];
        int pick;
        in_p[0] = sp_dout_0;
        in_p[1] = sp_dout_1;
        m_loaded = 1'b0;
        if (!reset_n) begin
            m_has[0] = 0; m_has[1] = 0;
            m_out = '0; m_sp0 = '0; m_sp1 = '0;
            m_turn = 0; m_g[0] = 0; m_g[1] = 0; m_stall = 0;
            sb0.delete(); sb1.delete();
        end else begin
            had[0] = m_has[0];
            had[1] = m_has[1];
            if (m_out[VB] && resend) begin
                m_stall++;
            end else begin
                pick = -1;
                if (had[0] && had[1]) pick = m_turn;
                else if (had[0])      pick = 0;
                else if (had[1])      pick = 1;
                if (pick >= 0) begin
                    m_out = m_held[pick];
                    m_has[pick] = 0;
                    m_turn = 1 - pick;
                    m_g[pick]++;
                    m_loaded = 1'b1;
                end else begin
                    m_out = '0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!had[i] && in_p[i][VB]) begin
                    m_held[i] = in_p[i];
                    m_has[i] = 1;
                    if (i == 0) sb0.push_back(in_p[i]);
                    else        sb1.push_back(in_p[i]);
                end
            end
            m_sp0 = (din_leaf_bft2interface[VB] && !din_leaf_bft2interface[AB])
                    ? din_leaf_bft2interface : '0;
            m_sp1 = (din_leaf_bft2interface[VB] && din_leaf_bft2interface[AB])
                    ? din_leaf_bft2interface : '0;
        end
    end

    // Per-cycle comparison against the model, plus source scoreboard.
    always @(negedge clk) begin
        logic [W-1:0] exp_p;
        if (chk_en) begin
            check("dout", dout_leaf_interface2bft, m_out);
            check("sp_din_0", sp_din_0, m_sp0);
            check("sp_din_1", sp_din_1, m_sp1);
            check("sp_resend_0", sp_resend_0, m_has[0]);
            check("sp_resend_1", sp_resend_1, m_has[1]);
`ifdef SUBDIV_ARB_PERF_EN
            check("grant_cnt_0", grant_cnt_0, m_g[0]);
            check("grant_cnt_1", grant_cnt_1, m_g[1]);
            check("stall_cnt", stall_cnt, m_stall);
`endif
            if (m_loaded) begin
                exp_p = '0;
                if (dout_leaf_interface2bft[SB] == 1'b0 && sb0.size() > 0)
                    exp_p = sb0.pop_front();
                else if (dout_leaf_interface2bft[SB] == 1'b1 && sb1.size() > 0)
                    exp_p = sb1.pop_front();
                check("scoreboard", dout_leaf_interface2bft, exp_p);
            end
        end
    end

    // Sub-page generators: re-present a rejected packet, else next one.
    logic [W-1:0] cur [2];
    int           gen_left [2];
    int           gen_seq  [2];
    bit           rnd = 1'b0;

    function automatic logic [W-1:0] mk(input int src, input int seq);
        logic [W-1:0] p;
        p = '0;
        p[VB] = 1'b1;
        p[SB] = src[0];
        p[31:0] = seq;
        return p;
    endfunction

    task automatic step();
        logic [1:0]  rj;
        logic [63:0] r;
        rj = {sp_resend_1, sp_resend_0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rnd) begin
                r = {$urandom, $urandom};
                cur[i] = r[W-1:0];
                cur[i][VB] = ($urandom_range(0, 9) < 6);
                cur[i][SB] = i[0];
            end else if (!rj[i] || !cur[i][VB]) begin
                if (gen_left[i] > 0) begin
                    cur[i] = mk(i, gen_seq[i]);
                    gen_seq[i]++;
                    gen_left[i]--;
                end else begin
                    cur[i] = '0;
                end
            end
        end
        sp_dout_0 = cur[0];
        sp_dout_1 = cur[1];
    endtask

    // Fairness observer state.
    bit           f_on = 1'b0;
    int           f_n [2];
    int           f_last = -1;
    int           f_first = -1;
    int           f_alt = 0;
    int           f_gap = 0;
    logic [W-1:0] f_prev = '0;

    task automatic observe();
        int s;
        if (f_on) begin
            if (dout_leaf_interface2bft[VB]) begin
                if (dout_leaf_interface2bft != f_prev) begin
                    s = int'(dout_leaf_interface2bft[SB]);
                    if (f_first < 0) f_first = s;
                    if (f_last == s) f_alt++;
                    f_last = s;
                    f_n[s]++;
                end
            end else if ((f_n[0] + f_n[1]) > 0 && (f_n[0] + f_n[1]) < 40) begin
                f_gap++;
            end
            f_prev = dout_leaf_interface2bft;
        end
    endtask

    logic [W-1:0] pk;
    int           waited;

    initial begin
        reset_n = 1'b0;
        resend = 1'b0;
        din_leaf_bft2interface = '0;
        sp_dout_0 = '0;
        sp_dout_1 = '0;
        cur[0] = '0; cur[1] = '0;
        gen_left[0] = 0; gen_left[1] = 0;
        gen_seq[0] = 0;  gen_seq[1] = 0;
        f_n[0] = 0; f_n[1] = 0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        step();
        check("reset_dout", dout_leaf_interface2bft, '0);
        check("reset_resend", {sp_resend_1, sp_resend_0}, 2'b00);
        check("reset_din", {sp_din_1, sp_din_0}, '0);
        reset_n = 1'b1;
        step();

        // Fairness with a 3-cycle leaf stall mid-stream.
        gen_left[0] = 20; gen_left[1] = 20;
        f_on = 1'b1;
        for (int k = 0; k < 70; k++) begin
            resend = (k >= 20 && k < 23);
            step();
            observe();
        end
        resend = 1'b0;
        f_on = 1'b0;
        check("fair_first_src", f_first, 0);
        check("fair_grants_0", f_n[0], 20);
        check("fair_grants_1", f_n[1], 20);
        check("fair_alternation", f_alt, 0);
        check("fair_no_bubble", f_gap, 0);
`ifdef SUBDIV_ARB_PERF_EN
        check("perf_grant_0", grant_cnt_0, 20);
        check("perf_grant_1", grant_cnt_1, 20);
        check("perf_stall", stall_cnt, 3);
`endif

        // Single-source latency: accept, slot, output.
        pk = 49'h1_0000_0000_00A5;
        cur[0] = pk;
        sp_dout_0 = pk;
        check("single_resend_t0", sp_resend_0, 1'b0);
        step();
        check("single_resend_t1", sp_resend_0, 1'b1);
        check("single_dout_t1", dout_leaf_interface2bft, '0);
        step();
        check("single_dout_t2", dout_leaf_interface2bft, pk);
        check("single_resend_t2", sp_resend_0, 1'b0);
        step();
        check("single_dout_t3", dout_leaf_interface2bft, '0);

        // Leaf backpressure: 5 resend cycles, 6 cycles of the same packet.
        gen_left[0] = 4; gen_left[1] = 4;
        waited = 0;
        while (!dout_leaf_interface2bft[VB] && waited < 10) begin
            step();
            waited++;
        end
        check("bp_output_fills", dout_leaf_interface2bft[VB], 1'b1);
        pk = dout_leaf_interface2bft;
        resend = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold", dout_leaf_interface2bft, pk);
            if (k >= 1)
                check("bp_resend_both", {sp_resend_1, sp_resend_0}, 2'b11);
        end
        resend = 1'b0;
        step();
        check("bp_release", dout_leaf_interface2bft == pk, 1'b0);
        for (int k = 0; k < 20; k++) step();
        check("bp_sb0_empty", sb0.size(), 0);
        check("bp_sb1_empty", sb1.size(), 0);

        // Downstream steering by address bit.
        pk = '0; pk[VB] = 1'b1; pk[AB] = 1'b1; pk[7:0] = 8'h11;
        din_leaf_bft2interface = pk;
        step();
        check("dn_to_1", sp_din_1, pk);
        check("dn_to_1_other", sp_din_0, '0);
        pk = '0; pk[VB] = 1'b1; pk[7:0] = 8'h22;
        din_leaf_bft2interface = pk;
        step();
        check("dn_to_0", sp_din_0, pk);
        check("dn_to_0_other", sp_din_1, '0);
        pk = '0; pk[AB] = 1'b1; pk[7:0] = 8'h33;
        din_leaf_bft2interface = pk;
        step();
        check("dn_invalid", {sp_din_1, sp_din_0}, '0);
        din_leaf_bft2interface = '0;

        // Randomised traffic on every port.
        rnd = 1'b1;
        for (int k = 0; k < 400; k++) begin
            resend = ($urandom_range(0, 3) == 0);
            din_leaf_bft2interface = {$urandom_range(0, 1) == 1, 48'({$urandom, $urandom})};
            step();
        end
        rnd = 1'b0;
        cur[0] = '0; cur[1] = '0;
        resend = 1'b0;
        din_leaf_bft2interface = '0;
        for (int k = 0; k < 10; k++) step();
        check("rnd_sb0_empty", sb0.size(), 0);
        check("rnd_sb1_empty", sb1.size(), 0);

        // Reset with slots and output full.
        gen_left[0] = 3; gen_left[1] = 3;
        waited = 0;
        while (!dout_leaf_interface2bft[VB] && waited < 10) begin
            step();
            waited++;
        end
        resend = 1'b1;
        step();
        step();
        check("pre_reset_full", {dout_leaf_interface2bft[VB], sp_resend_1, sp_resend_0}, 3'b111);
        reset_n = 1'b0;
        gen_left[0] = 0; gen_left[1] = 0;
        step();
        check("mid_reset_dout", dout_leaf_interface2bft, '0);
        check("mid_reset_resend", {sp_resend_1, sp_resend_0}, 2'b00);
        reset_n = 1'b1;
        resend = 1'b0;
        cur[0] = '0; cur[1] = '0;
        sp_dout_0 = '0; sp_dout_1 = '0;
        step();
        check("post_reset_resend", {sp_resend_1, sp_resend_0}, 2'b00);
        gen_left[0] = 1; gen_left[1] = 1;
        pk = mk(0, gen_seq[0]);
        waited = 0;
        while (!dout_leaf_interface2bft[VB] && waited < 10) begin
            step();
            waited++;
        end
        check("post_reset_first_grant", dout_leaf_interface2bft, pk);
        for (int k = 0; k < 5; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/subdivide_leaf_arbiter.md
# subdivide_leaf_arbiter

Shares one BFT leaf port between the two halves of a double-subdivided page so both sub-pages reach the network through a single leaf. Upstream packets from the two sub-pages are buffered in one-entry slots and merged onto the leaf by a 2-way round-robin arbiter with resend-based backpressure. Downstream packets from the leaf are steered to one sub-page by an address bit. Sits between the BFT leaf interface and the two sub-page instances inside the parent page pblock.

## Interface

Parameters:
- PACKET_W, 49, leaf packet width; bit PACKET_W-1 is the valid bit.
- ADDR_SEL_BIT, 43, downstream packet bit selecting the destination sub-page (0 → sub-page 0, 1 → sub-page 1).

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- din_leaf_bft2interface  in  PACKET_W  packet from the BFT leaf.
- dout_leaf_interface2bft  out  PACKET_W  merged packet to the BFT leaf.
- resend  in  1  leaf rejects the packet currently on dout_leaf_interface2bft.
- sp_dout_0 / sp_dout_1  in  PACKET_W  packets from sub-page 0 / sub-page 1.
- sp_din_0 / sp_din_1  out  PACKET_W  steered downstream packets to each sub-page.
- sp_resend_0 / sp_resend_1  out  1  the sub-page's packet this cycle is rejected; the sub-page re-presents it.

## Operation

- **Slots:** one entry per sub-page, holding a packet and a full flag.
  - sp_resend_i is registered and equals slot_full[i].
  - A valid sp_dout_i presented while the slot is empty loads the slot. It is full from the next cycle.
  - A valid packet presented while the slot is full is rejected. sp_resend_i is already high and the slot is unchanged.
- **Output register (OR):** drives dout_leaf_interface2bft.
  - OR is free when its valid bit is 0, or its valid bit is 1 and resend is 0.
  - When OR is free, it loads the arbiter winner and clears that slot, or loads all-zero if no slot is full.
  - When OR is not free (valid and resend), it holds its packet and no slot is drained.
- **Round-robin:**
  - Pointer rr starts at 0.
  - Both slots full: grant rr.
  - One slot full: grant it.
  - After any grant to i, rr becomes 1-i. rr is unchanged when nothing is granted.
- **Downstream:**
  - din_leaf_bft2interface is registered once.
  - If valid, it goes to sp_din_0 when bit ADDR_SEL_BIT=0, otherwise to sp_din_1. The other output is all-zero.
  - An invalid input gives zero on both outputs.
  - There is no downstream backpressure.
- **Invalid inputs:** invalid sp_dout_i packets (valid bit 0) are ignored and never load a slot.

## Timing

- **Reset values:** all outputs 0. Slots empty, OR empty, rr=0.
- **Reset mid-operation:** buffered packets are discarded, so the sub-pages and BFT must tolerate the loss. sp_resend_* are 0 the cycle after reset deasserts.
- **Upstream latency:** a packet accepted at cycle t sits in its slot at t+1. With OR free and the packet winning, it appears on dout_leaf_interface2bft at t+2.
- **Upstream throughput:**
  - Per sub-page: 1 packet per 2 cycles, because the slot is still flagged full in the cycle it drains.
  - Aggregate with both sub-pages active: 1 packet per cycle.
- **Held output:** resend held high for N cycles keeps the same packet on the output for N+1 cycles. Slots stay full and both sub-pages see sp_resend high.
- **Simultaneous events:** a slot drain and a reject of a new packet to that slot in the same cycle is legal. The new packet is re-presented and loads the following cycle.
- **Downstream latency:** exactly 1 cycle.

## Configuration

- **SUBDIV_ARB_PERF_EN defined:**
  - Adds outputs grant_cnt_0 and grant_cnt_1, 32-bit each. Each counts packets loaded into OR from that sub-page.
  - Adds output stall_cnt, 32-bit, counting cycles with OR valid and resend high.
  - Counters wrap at 2^32, reset to 0, and are read-only.
- **Not defined:** none of these ports or registers exist, and behaviour is otherwise identical.

## Structure

- **Shared package subdivide_pkg:**
  - Constants PACKET_W=49 and VALID_BIT=PACKET_W-1.
  - Typedef packet_t as logic [PACKET_W-1:0].
  - Function pkt_valid(packet_t).
- **Sub-module subdivide_rr_arb2:**
  - 2-requester round-robin grant with registered pointer.
  - Inputs req[1:0] and advance; outputs a one-hot grant[1:0].
  - The top level instantiates it once.

## Test plan

- **Single-source flow:** sub-page 0 presents valid packet 0x1_0000_0000_00A5 at cycle 10 with no resend.
  - Expect it on dout_leaf_interface2bft at cycle 12.
  - Expect sp_resend_0 high in cycle 11 only.
- **Round-robin fairness:** both sub-pages present continuously for 40 cycles.
  - Expect output sources to alternate 0,1,0,1 starting with sub-page 0.
  - Expect 20 grants each and no cycle with the output valid bit 0 after the pipeline fills.
- **Leaf backpressure:** resend held high for 5 cycles while the output holds packet P.
  - Expect P unchanged for 6 cycles.
  - Expect both sp_resend high throughout.
  - Expect no packet loss or duplication afterwards, checked by scoreboard.
- **Downstream steering:** drive a valid packet with bit 43=1, then one with bit 43=0, then an invalid packet.
  - Expect sub-page 1, then sub-page 0, then zero on both, each 1 cycle later.
- **Reset mid-stream:** assert reset_n=0 for 1 cycle while both slots and OR are full.
  - Expect all outputs 0 on the next cycle.
  - Expect rr=0: after release, simultaneous requests are granted to sub-page 0 first.
- **Counters (SUBDIV_ARB_PERF_EN):** the fairness scenario plus 3 resend cycles.
  - Expect grant_cnt_0=grant_cnt_1=20 and stall_cnt=3.
